// File: rtl/toggle_req_pkg.sv
// Shared types and constants for the toggle request generator and its gap counter.
package toggle_req_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_CNT_W  = 8;
    localparam int DEF_PER_W  = 8;
    localparam int MIN_PERIOD = 1;

endpackage

// File: rtl/toggle_gap_ctr.sv
// Loadable down-counter that times the idle cycles between consecutive toggle pulses.
module toggle_gap_ctr
    import toggle_req_pkg::*;
#(
    parameter int PER_W = DEF_PER_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [PER_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_is_one
);

    logic [PER_W-1:0] r_count;

    // Never steps below zero; the owner leaves GAP once the count reads one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - PER_W'(1);
        end
    end

    assign o_is_one = (r_count == PER_W'(1));

endmodule

// File: rtl/toggle_req_gen.sv
// Emits N single-cycle toggle requests P cycles apart and tracks the expected T flip-flop state.
// Build option: TOGGLE_REQ_GEN_CHECK_EN adds a sticky q_fb versus q_exp mismatch flag on err.
module toggle_req_gen
    import toggle_req_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int PER_W = DEF_PER_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [PER_W-1:0] cmd_period,
    input  logic             abort,
    output logic             t,
    output logic             busy,
    output logic             done,
    output logic             q_exp,
    input  logic             q_fb,
    output logic             err
);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_pulses_left;
    logic [PER_W-1:0] r_period;
    logic [PER_W-1:0] w_period_eff;
    logic             r_q_exp;
    logic             w_accept;
    logic             w_last_pulse;
    logic             w_period_one;
    logic             w_gap_load;
    logic             w_gap_dec;
    logic             w_gap_is_one;

    // A zero period would never advance, so it is promoted to back-to-back pulses.
    assign w_period_eff = (cmd_period < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : cmd_period;
    assign w_accept     = cmd_valid && (r_state == ST_IDLE) && !abort;
    assign w_last_pulse = (r_pulses_left == CNT_W'(1));
    assign w_period_one = (r_period == PER_W'(MIN_PERIOD));
    assign w_gap_load   = (r_state == ST_PULSE);
    assign w_gap_dec    = (r_state == ST_GAP);

    toggle_gap_ctr #(
        .PER_W(PER_W)
    ) u_gap_ctr (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_gap_load),
        .i_load_val (r_period - PER_W'(1)),
        .i_dec      (w_gap_dec),
        .o_is_one   (w_gap_is_one)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = (cmd_count == '0) ? ST_DONE : ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_last_pulse) begin
                    w_state_next = ST_DONE;
                end else if (!w_period_one) begin
                    w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_gap_is_one) begin
                    w_state_next = ST_PULSE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        t         = (r_state == ST_PULSE);
        done      = (r_state == ST_DONE);
        cmd_ready = (r_state == ST_IDLE);
        busy      = (r_state != ST_IDLE);
    end

    // A pulse cycle always counts and toggles parity, even when abort arrives alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pulses_left <= '0;
            r_period      <= PER_W'(MIN_PERIOD);
            r_q_exp       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pulses_left <= cmd_count;
                r_period      <= w_period_eff;
            end
            if (r_state == ST_PULSE) begin
                r_pulses_left <= r_pulses_left - CNT_W'(1);
                r_q_exp       <= ~r_q_exp;
            end
        end
    end

    assign q_exp = r_q_exp;

`ifdef TOGGLE_REQ_GEN_CHECK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (q_fb != r_q_exp) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_q_fb;

    assign w_unused_q_fb = q_fb;
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_toggle_req_gen.sv
// Scoreboard bench for toggle_req_gen: commands push expected t/done events, a monitor pops and checks them.
module tb_toggle_req_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_count = '0;
    logic [7:0] cmd_period = '0;
    logic       abort = 1'b0;
    logic       bad = 1'b0;
    logic       tff;
    logic       q_fb;
    logic       cmd_ready, t, busy, done, q_exp, err;

    toggle_req_gen #(
        .CNT_W(8),
        .PER_W(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_count  (cmd_count),
        .cmd_period (cmd_period),
        .abort      (abort),
        .t          (t),
        .busy       (busy),
        .done       (done),
        .q_exp      (q_exp),
        .q_fb       (q_fb),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural T flip-flop fed by the DUT's requests; bad inverts the feedback on demand.
    always @(posedge clk) begin
        if (reset) tff <= 1'b0;
        else if (t) tff <= ~tff;
    end
    assign q_fb = tff ^ bad;

    typedef struct {
        int kind;   // 0 = t pulse, 1 = done
        int cyc;
        int q;
    } ev_t;

    ev_t exp_q[$];
    ev_t ev;
    int  parity = 0;
    int  checks = 0;
    int  failures = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                ev = exp_q.pop_front();
                chk("missed_event_cyc", cyc, ev.cyc);
            end
            if (t === 1'b1 || done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event_cyc", cyc, -1);
                end else begin
                    ev = exp_q.pop_front();
                    chk("event_cyc", cyc, ev.cyc);
                    chk("event_kind", (done === 1'b1) ? 1 : 0, ev.kind);
                    chk("event_q_exp", int'(q_exp), ev.q);
                end
            end
        end
    end

    // Called at a negedge; the command is accepted on the next rising edge, edge k.
    task automatic send(input int n, input int p, input int n_exp, input bit with_done, output int k);
        int w;
        int pe;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) chk("ready_timeout", int'(cmd_ready), 1);
        k  = cyc + 1;
        pe = (p == 0) ? 1 : p;
        for (int i = 0; i < n_exp; i++) begin
            exp_q.push_back('{kind: 0, cyc: k + i * pe, q: parity});
            parity ^= 1;
        end
        if (with_done)
            exp_q.push_back('{kind: 1, cyc: (n == 0) ? k : k + (n - 1) * pe + 1, q: parity});
        cmd_valid  = 1'b1;
        cmd_count  = 8'(n);
        cmd_period = 8'(p);
        @(negedge clk);
        cmd_valid = 1'b0;
        $display("CMD count=%0d period=%0d accept_edge=%0d expected_pulses=%0d", n, p, k, n_exp);
    endtask

    task automatic wait_idle(output int c);
        int w;
        w = 0;
        while (busy !== 1'b0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        c = cyc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int c;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_t", int'(t), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_q_exp", int'(q_exp), 0);
        chk("reset_cmd_ready", int'(cmd_ready), 1);
        chk("reset_err", int'(err), 0);

        // Four back-to-back pulses with period 0 treated as 1.
        send(4, 0, 4, 1'b1, k);
        wait_idle(c);
        chk("p0_idle_cyc", c, k + 5);
        chk("p0_q_exp", int'(q_exp), parity);

        // Three pulses four cycles apart.
        send(3, 4, 3, 1'b1, k);
        wait_idle(c);
        chk("p4_idle_cyc", c, k + 10);
        chk("p4_q_exp", int'(q_exp), parity);

        // Zero count: only a done pulse.
        send(0, 5, 0, 1'b1, k);
        chk("zero_ready_in_done", int'(cmd_ready), 0);
        wait_idle(c);
        chk("zero_idle_cyc", c, k + 1);
        chk("zero_ready_after", int'(cmd_ready), 1);

        // Single pulse boundary.
        send(1, 1, 1, 1'b1, k);
        wait_idle(c);
        chk("one_idle_cyc", c, k + 2);

        // cmd_valid while busy must be ignored.
        send(3, 2, 3, 1'b1, k);
        cmd_valid = 1'b1;
        cmd_count = 8'd9;
        @(negedge clk);
        chk("busy_ready_low", int'(cmd_ready), 0);
        @(negedge clk);
        chk("busy_ready_low2", int'(cmd_ready), 0);
        cmd_valid = 1'b0;
        wait_idle(c);
        chk("busy_idle_cyc", c, k + 6);

        // Abort in the gap after the second pulse: two pulses, no done.
        send(5, 3, 2, 1'b0, k);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_q_exp", int'(q_exp), parity);

        // Abort wins over a simultaneous accept in IDLE.
        cmd_valid = 1'b1;
        cmd_count = 8'd3;
        abort     = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        abort     = 1'b0;
        chk("abort_vs_accept_busy", int'(busy), 0);
        $display("CMD count=3 abort_same_cycle expected_pulses=0");

        repeat (8) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("err_clean_run", int'(err), 0);

        // Force the feedback to disagree with q_exp.
        bad = 1'b1;
        @(negedge clk);
        bad = 1'b0;
`ifdef TOGGLE_REQ_GEN_CHECK_EN
        chk("err_rise", int'(err), 1);
        repeat (3) @(negedge clk);
        chk("err_sticky", int'(err), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("err_cleared_by_reset", int'(err), 0);
`else
        chk("err_disabled", int'(err), 0);
        repeat (3) @(negedge clk);
        chk("err_disabled_hold", int'(err), 0);
`endif
        $display("CMD checker_probe err=%0d", err);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
